// File: rtl/irq_sched.sv
// Round-robin scheduler folding several one-cycle interrupt sources onto one SoC line.
// Optional build macro IRQ_SCHED_LEVEL_EN: level output, grant on software clear.
module irq_sched #(
  parameter logic [4:0]  BASE_ADDR = 5'h0,
  parameter int unsigned NUM_SRC   = 4,
  parameter int unsigned PULSE_LEN = 16,
  parameter int unsigned HOLDOFF   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4:0]         csr_a,
  input  logic [7:0]         csr_di,
  input  logic               csr_we,
  output logic [7:0]         csr_do,
  input  logic [NUM_SRC-1:0] irq_in,
  output logic               irq_out,
  output logic               busy
);

  localparam int unsigned IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0] en;
  logic [NUM_SRC-1:0] pend;
  logic [NUM_SRC-1:0] ovr;
  logic [2:0]         stat_src;
  logic [NUM_SRC-1:0] grant_mask;

  // CSR decode: block occupies BASE_ADDR+0..+3
  logic [4:0]         offset;
  logic               hit;
  logic [NUM_SRC-1:0] wmask;
  logic               en_we;
  logic [NUM_SRC-1:0] pend_w1c;
  logic [NUM_SRC-1:0] ovr_w1c;
  logic               unused_di;

  assign offset    = csr_a - BASE_ADDR;
  assign hit       = (offset[4:2] == 3'b000);
  assign wmask     = csr_di[NUM_SRC-1:0];
  assign unused_di = ^csr_di;
  assign en_we     = csr_we && hit && (offset[1:0] == 2'd0);
  assign pend_w1c  = (csr_we && hit && (offset[1:0] == 2'd1)) ? wmask : '0;
  assign ovr_w1c   = (csr_we && hit && (offset[1:0] == 2'd3)) ? wmask : '0;

  always_comb begin
    csr_do = 8'h00;
    if (hit) begin
      case (offset[1:0])
        2'd0:    csr_do = 8'(en);
        2'd1:    csr_do = 8'(pend);
        2'd2:    csr_do = {busy, 4'b0000, stat_src};
        default: csr_do = 8'(ovr);
      endcase
    end
  end

  // Event latch; a new event always wins over any clear in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      en   <= '0;
      pend <= '0;
      ovr  <= '0;
    end else begin
      if (en_we) en <= wmask;
      pend <= (pend & ~pend_w1c & ~grant_mask) | irq_in;
      ovr  <= (ovr & ~ovr_w1c) | (irq_in & pend);
    end
  end

`ifdef IRQ_SCHED_LEVEL_EN

  logic [NUM_SRC-1:0] remain;
  logic [2:0]         low_idx;

  assign remain     = pend & ~pend_w1c & en;
  assign grant_mask = '0;

  // Lowest-index enabled source left pending after a software clear
  always_comb begin
    low_idx = 3'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (remain[i]) low_idx = 3'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_src <= 3'd0;
      irq_out  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      irq_out <= |(pend & en);
      busy    <= 1'b0;
      if ((|pend_w1c) && (|remain)) stat_src <= low_idx;
    end
  end

`else

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_HOLDOFF} state_t;

  localparam logic [7:0] PULSE_LOAD = 8'(PULSE_LEN - 1);
  localparam logic [7:0] HOLD_LOAD  = 8'(HOLDOFF - 1);
  localparam bit         HAS_HOLD   = (HOLDOFF != 0);

  state_t             state;
  logic [7:0]         cnt;
  logic [2:0]         rr;
  logic [2:0]         rr_next;
  logic [NUM_SRC-1:0] req;
  logic               found;
  logic [IW-1:0]      winner;
  logic [3:0]         pos;

  assign req     = pend & en;
  assign rr_next = (stat_src == 3'(NUM_SRC - 1)) ? 3'd0 : stat_src + 3'd1;

  // First requesting source at or after rr, wrapping mod NUM_SRC
  always_comb begin
    found  = 1'b0;
    winner = '0;
    pos    = 4'd0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      pos = 4'(rr) + 4'(k);
      if (pos >= 4'(NUM_SRC)) pos = pos - 4'(NUM_SRC);
      if (!found && req[pos[IW-1:0]]) begin
        found  = 1'b1;
        winner = pos[IW-1:0];
      end
    end
  end

  assign grant_mask = (state == S_IDLE && found)
                      ? ({{(NUM_SRC-1){1'b0}}, 1'b1} << winner) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      stat_src <= 3'd0;
      irq_out  <= 1'b0;
      busy     <= 1'b0;
      cnt      <= 8'd0;
      rr       <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            stat_src <= 3'(winner);
            irq_out  <= 1'b1;
            busy     <= 1'b1;
            cnt      <= PULSE_LOAD;
            state    <= S_PULSE;
          end
        end
        S_PULSE: begin
          if (cnt == 8'd0) begin
            irq_out <= 1'b0;
            rr      <= rr_next;
            if (HAS_HOLD) begin
              cnt   <= HOLD_LOAD;
              state <= S_HOLDOFF;
            end else begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_HOLDOFF: begin
          if (cnt == 8'd0) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`endif

endmodule
